// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared types and constants for the k-means iteration controller.
//   state_t   - controller FSM states
//   ACC_W     - accumulator sum width per dimension
//   PT_W      - point / centroid coordinate width
//   CNT_W     - accumulator point-count width
//   DRAIN_CYC - cycles between the last point read and accumulator readout
package kmeans_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    UPDATE,
    CHECK,
    FIN
  } state_t;

  localparam int ACC_W     = 64;
  localparam int PT_W      = 32;
  localparam int CNT_W     = 32;
  localparam int DRAIN_CYC = 2;

endpackage

// File: rtl/kmeans_seq_div.sv
// kmeans_seq_div: 64/32 unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - load dividend/divisor; accepted only while busy=0
//   dividend   - 64-bit numerator
//   divisor    - 32-bit denominator (caller never issues zero)
//   busy       - high during the 64 iteration cycles
//   valid      - one-cycle strobe: quotient holds the result
//   quotient   - low 32 bits of the full 64-bit quotient
// Handshake: start is taken on a cycle with busy=0; exactly 64 cycles later
// valid pulses for one cycle and quotient stays stable until the next start.
module kmeans_seq_div
  import kmeans_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ACC_W-1:0]   dividend,
  input  logic [CNT_W-1:0]   divisor,
  output logic               busy,
  output logic               valid,
  output logic [PT_W-1:0]    quotient
);

  // dvd shifts the dividend out at the top and collects quotient bits at
  // the bottom; after 64 steps it holds the full quotient.
  logic [ACC_W-1:0] dvd;
  logic [CNT_W-1:0] rem;
  logic [6:0]       cnt;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W:0]   diff;

  always_comb begin
    rem_sh = {rem, dvd[ACC_W-1]};
    diff   = rem_sh - {1'b0, divisor};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd   <= '0;
      rem   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start && !busy) begin
        dvd  <= dividend;
        rem  <= '0;
        cnt  <= 7'd64;
        busy <= 1'b1;
      end else if (busy) begin
        // diff[CNT_W] is the borrow: set means the trial subtract failed.
        dvd <= {dvd[ACC_W-2:0], ~diff[CNT_W]};
        rem <= diff[CNT_W] ? rem_sh[CNT_W-1:0] : diff[CNT_W-1:0];
        cnt <= cnt - 7'd1;
        if (cnt == 7'd1) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign quotient = dvd[PT_W-1:0];

endmodule

// File: rtl/kmeans_iter_ctrl.sv
// kmeans_iter_ctrl: k-means pass sequencer. Each pass clears the accumulators,
// streams all points, waits for the pipeline to drain, then divides every
// populated cluster's sums by its count and writes the new centroids. Passes
// repeat until nothing changes or max_iter passes have completed.
// Optional build macro: KMEANS_ROUND_EN (round-half-up division instead of
// truncation).
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   start                 - run request, ignored while busy
//   num_points, max_iter  - run parameters, sampled on accepted start
//   busy, done            - run in progress / one-cycle end-of-run pulse
//   converged, iter_count - run result, held until next accepted start
//   pt_rd, pt_addr        - point memory read (data one cycle later)
//   acc_clear, acc_valid  - accumulator clear / point-valid
//   acc_rd_idx            - cluster selected for accumulator/centroid readout
//   acc_sum, acc_cnt      - readout of cluster acc_rd_idx
//   cen_old               - current centroid of cluster acc_rd_idx
//   cen_we, cen_widx, cen_wdim, cen_wdata - centroid write port
//   dbg_state             - current FSM state
// Handshake: every strobe here (pt_rd, acc_clear, acc_valid, cen_we) is a
// single-cycle qualifier with no back-pressure; the consumer must accept it
// on the cycle it is high.
module kmeans_iter_ctrl
  import kmeans_pkg::*;
#(
  parameter  int n  = 8,
  parameter  int d  = 2,
  parameter  int AW = 16,
  localparam int DW = (d > 1) ? $clog2(d) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       num_points,
  input  logic [15:0]         max_iter,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic [15:0]         iter_count,
  output logic                pt_rd,
  output logic [AW-1:0]       pt_addr,
  output logic                acc_clear,
  output logic                acc_valid,
  output logic [n-1:0]        acc_rd_idx,
  input  logic [d*ACC_W-1:0]  acc_sum,
  input  logic [CNT_W-1:0]    acc_cnt,
  input  logic [d*PT_W-1:0]   cen_old,
  output logic                cen_we,
  output logic [n-1:0]        cen_widx,
  output logic [DW-1:0]       cen_wdim,
  output logic [PT_W-1:0]     cen_wdata,
  output state_t              dbg_state
);

  state_t            state, state_nxt;
  logic [AW-1:0]     np_q;
  logic [15:0]       mi_q;
  logic [1:0]        drain_cnt;
  logic [DW-1:0]     upd_dim;
  logic              div_pending;
  logic              chg;
  logic              div_start, div_busy, div_valid;
  logic [PT_W-1:0]   div_q;
  logic [ACC_W-1:0]  div_dvd;
  logic [ACC_W-1:0]  cur_sum;
  logic [PT_W-1:0]   cur_old;
  logic              last_pt, last_dim, last_idx;
  logic              upd_skip, upd_adv, upd_end;
  logic [15:0]       iter_next;

  always_comb begin
    cur_sum   = acc_sum[ACC_W*upd_dim +: ACC_W];
    cur_old   = cen_old[PT_W*upd_dim +: PT_W];
    last_pt   = (pt_addr == np_q - AW'(1));
    last_dim  = (upd_dim == DW'(d - 1));
    last_idx  = &acc_rd_idx;
    iter_next = iter_count + 16'd1;
    // An empty cluster is skipped whole: no division, no write.
    upd_skip  = (state == UPDATE) && !div_pending && (acc_cnt == '0);
    div_start = (state == UPDATE) && !div_pending && (acc_cnt != '0);
    upd_adv   = upd_skip || ((state == UPDATE) && div_pending && div_valid);
    upd_end   = upd_skip || last_dim;
`ifdef KMEANS_ROUND_EN
    div_dvd   = cur_sum + ACC_W'(acc_cnt >> 1);
`else
    div_dvd   = cur_sum;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = (max_iter == 16'd0) ? FIN : CLEAR;
      CLEAR:  state_nxt = (np_q == '0) ? DRAIN : STREAM;
      STREAM: if (last_pt) state_nxt = DRAIN;
      DRAIN:  if (drain_cnt == 2'(DRAIN_CYC - 1)) state_nxt = UPDATE;
      UPDATE: if (upd_adv && upd_end && last_idx) state_nxt = CHECK;
      CHECK:  state_nxt = (!chg || iter_next == mi_q) ? FIN : CLEAR;
      FIN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      np_q        <= '0;
      mi_q        <= '0;
      iter_count  <= '0;
      converged   <= 1'b0;
      pt_addr     <= '0;
      acc_valid   <= 1'b0;
      drain_cnt   <= '0;
      acc_rd_idx  <= '0;
      upd_dim     <= '0;
      div_pending <= 1'b0;
      chg         <= 1'b0;
      cen_we      <= 1'b0;
      cen_widx    <= '0;
      cen_wdim    <= '0;
      cen_wdata   <= '0;
    end else begin
      cen_we    <= 1'b0;
      acc_valid <= pt_rd;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      case (state)
        IDLE: if (start) begin
          np_q       <= num_points;
          mi_q       <= max_iter;
          iter_count <= '0;
          converged  <= 1'b0;
        end
        CLEAR: begin
          chg         <= 1'b0;
          pt_addr     <= '0;
          acc_rd_idx  <= '0;
          upd_dim     <= '0;
          div_pending <= 1'b0;
        end
        STREAM: if (!last_pt) pt_addr <= pt_addr + AW'(1);
        UPDATE: begin
          if (div_start) div_pending <= 1'b1;
          if (div_pending && div_valid) begin
            div_pending <= 1'b0;
            cen_we      <= 1'b1;
            cen_widx    <= acc_rd_idx;
            cen_wdim    <= upd_dim;
            cen_wdata   <= div_q;
            if (div_q != cur_old) chg <= 1'b1;
          end
          if (upd_adv) begin
            if (upd_end) begin
              upd_dim    <= '0;
              acc_rd_idx <= acc_rd_idx + n'(1);
            end else begin
              upd_dim    <= upd_dim + DW'(1);
            end
          end
        end
        CHECK: begin
          iter_count <= iter_next;
          if (!chg) converged <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  kmeans_seq_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dvd),
    .divisor  (acc_cnt),
    .busy     (div_busy),
    .valid    (div_valid),
    .quotient (div_q)
  );

  assign busy      = (state != IDLE) && (state != FIN);
  assign done      = (state == FIN);
  assign pt_rd     = (state == STREAM);
  assign acc_clear = (state == CLEAR);
  assign dbg_state = state;

endmodule
